// File: rtl/input_checker.sv
// Memory-game input checker: synchronises eight raw buttons, compares presses against a latched
// pattern of 4/8/16 steps and reports pass/fail. Optional press timeout under `INPUT_TIMEOUT_EN.
module input_checker #(
    parameter int TIMEOUT_CYCLES = 1000,
    parameter int ECHO_CYCLES    = 8
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [2:0]  level,
    input  logic [47:0] pattern_bus,
    input  logic [7:0]  buttons,
    output logic [7:0]  led,
    output logic        busy,
    output logic [4:0]  hit_count,
    output logic        round_end,
    output logic        round_pass
);

    localparam int ECHO_W = $clog2(ECHO_CYCLES + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    function automatic logic is_onehot3(input logic [2:0] v);
        logic ok;
        case (v)
            3'b001:  ok = 1'b1;
            3'b010:  ok = 1'b1;
            3'b100:  ok = 1'b1;
            default: ok = 1'b0;
        endcase
        return ok;
    endfunction

    function automatic logic [4:0] steps_of(input logic [2:0] v);
        logic [4:0] s;
        case (v)
            3'b001:  s = 5'd4;
            3'b010:  s = 5'd8;
            3'b100:  s = 5'd16;
            default: s = 5'd0;
        endcase
        return s;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [2:0] index_of(input logic [7:0] v);
        logic [2:0] idx;
        idx = 3'd0;
        for (int i = 0; i < 8; i++) begin
            if (v[i]) begin
                idx = 3'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    state_t              state_r, state_nxt_s;
    logic [7:0]          sync1_r, sync2_r, prev_r;
    logic [47:0]         pattern_r;
    logic [4:0]          steps_r;
    logic [4:0]          hit_r, hit_nxt_s;
    logic                pass_r, pass_nxt_s;
    logic                busy_r, round_end_r;
    logic [7:0]          led_r;
    logic [ECHO_W-1:0]   echo_cnt_r;
    logic                load_s, echo_load_s;
    logic [7:0]          rise_s;
    logic                press_s, multi_s;
    logic [2:0]          idx_s, slot_s;
    logic [5:0]          slot_base_s;
    logic [4:0]          hit_inc_s;

`ifdef INPUT_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0]    tmo_r;
    logic                tmo_hit_s;
    assign tmo_hit_s = (tmo_r == TMO_W'(TIMEOUT_CYCLES - 1));
`endif

    assign rise_s      = sync2_r & ~prev_r;
    assign press_s     = |rise_s;
    assign multi_s     = (popcount8(rise_s) > 4'd1);
    assign idx_s       = index_of(rise_s);
    assign slot_base_s = 6'(hit_r[3:0]) * 6'd3;
    assign slot_s      = pattern_r[slot_base_s +: 3];
    assign hit_inc_s   = hit_r + 5'd1;

    // Two-flop synchroniser plus previous-sample register for rising-edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r <= 8'h00;
            sync2_r <= 8'h00;
            prev_r  <= 8'h00;
        end else begin
            sync1_r <= buttons;
            sync2_r <= sync1_r;
            prev_r  <= sync2_r;
        end
    end

    // Next-state and round bookkeeping; a multi-edge press is never a match.
    always_comb begin
        state_nxt_s = state_r;
        hit_nxt_s   = hit_r;
        pass_nxt_s  = pass_r;
        load_s      = 1'b0;
        echo_load_s = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start && is_onehot3(level)) begin
                    load_s      = 1'b1;
                    hit_nxt_s   = 5'd0;
                    pass_nxt_s  = 1'b0;
                    state_nxt_s = ST_COLLECT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_COLLECT: begin
                if (press_s) begin
                    echo_load_s = 1'b1;
                    if (!multi_s && (idx_s == slot_s)) begin
                        hit_nxt_s = hit_inc_s;
                        if (hit_inc_s == steps_r) begin
                            pass_nxt_s  = 1'b1;
                            state_nxt_s = ST_DONE;
                        end else begin
                            state_nxt_s = ST_COLLECT;
                        end
                    end else begin
                        pass_nxt_s  = 1'b0;
                        state_nxt_s = ST_DONE;
                    end
`ifdef INPUT_TIMEOUT_EN
                end else if (tmo_hit_s) begin
                    pass_nxt_s  = 1'b0;
                    state_nxt_s = ST_DONE;
`endif
                end else begin
                    state_nxt_s = ST_COLLECT;
                end
            end
            ST_DONE: begin
                state_nxt_s = ST_IDLE;
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // State, round result and status outputs, all registered from the next-state decode.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            hit_r       <= 5'd0;
            pass_r      <= 1'b0;
            busy_r      <= 1'b0;
            round_end_r <= 1'b0;
            pattern_r   <= 48'h0;
            steps_r     <= 5'd0;
        end else begin
            state_r     <= state_nxt_s;
            hit_r       <= hit_nxt_s;
            pass_r      <= pass_nxt_s;
            busy_r      <= (state_nxt_s == ST_COLLECT);
            round_end_r <= (state_nxt_s == ST_DONE);
            if (load_s) begin
                pattern_r <= pattern_bus;
                steps_r   <= steps_of(level);
            end
        end
    end

    // Echo LEDs: reloaded by every COLLECT press, then cleared after ECHO_CYCLES cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            led_r      <= 8'h00;
            echo_cnt_r <= '0;
        end else if (echo_load_s) begin
            led_r      <= rise_s;
            echo_cnt_r <= ECHO_W'(ECHO_CYCLES);
        end else if (echo_cnt_r != '0) begin
            echo_cnt_r <= echo_cnt_r - ECHO_W'(1);
            if (echo_cnt_r == ECHO_W'(1)) begin
                led_r <= 8'h00;
            end
        end
    end

`ifdef INPUT_TIMEOUT_EN
    // Idle-input counter: restarts on every press and outside COLLECT.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_r <= '0;
        end else if ((state_r != ST_COLLECT) || press_s) begin
            tmo_r <= '0;
        end else begin
            tmo_r <= tmo_r + TMO_W'(1);
        end
    end
`endif

    assign led        = led_r;
    assign busy       = busy_r;
    assign hit_count  = hit_r;
    assign round_end  = round_end_r;
    assign round_pass = pass_r;

endmodule

// File: tb/tb_input_checker.sv
// Scoreboard bench for input_checker: directed scenarios plus randomized rounds checked
// against a step-by-step reference model of the game rules.
module tb_input_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [2:0]  level;
    logic [47:0] pattern_bus;
    logic [7:0]  buttons;
    logic [7:0]  led;
    logic        busy;
    logic [4:0]  hit_count;
    logic        round_end;
    logic        round_pass;

    int total = 0;
    int bad   = 0;
    logic [5:0] expq[$];

    input_checker #(.TIMEOUT_CYCLES(1000), .ECHO_CYCLES(8)) dut (
        .clk(clk), .rst(rst), .start(start), .level(level), .pattern_bus(pattern_bus),
        .buttons(buttons), .led(led), .busy(busy), .hit_count(hit_count),
        .round_end(round_end), .round_pass(round_pass)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [47:0] act, input logic [47:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic do_start(input logic [2:0] l, input logic [47:0] p);
        @(negedge clk);
        level = l;
        pattern_bus = p;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic press(input logic [7:0] b);
        @(negedge clk);
        buttons = b;
        repeat (4) @(negedge clk);
        buttons = 8'h00;
        repeat (3) @(negedge clk);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk("idle_bound", busy, 1'b0);
        repeat (2) @(negedge clk);
    endtask

    // Reference model: walks the press list through the game rules, returns the result.
    function automatic logic [5:0] model(input int steps, input logic [47:0] pat, input logic [7:0] pr[$]);
        int hits;
        hits = 0;
        foreach (pr[i]) begin
            logic [2:0] want;
            want = pat[3*hits +: 3];
            if ($countones(pr[i]) == 1 && pr[i] == (8'h01 << want)) begin
                hits++;
                if (hits == steps) return {1'b1, 5'(hits)};
            end else begin
                return {1'b0, 5'(hits)};
            end
        end
        return 6'h3f;
    endfunction

    initial begin
        logic [7:0]  prs[$];
        logic [47:0] pat;
        logic [5:0]  res;
        int          k, cnt;

        rst = 1'b1; start = 1'b0; level = 3'b000; pattern_bus = 48'h0; buttons = 8'h00;

        fork
            begin : monitor
                logic re_prev;
                logic [5:0] e;
                re_prev = 1'b0;
                forever begin
                    @(negedge clk);
                    if (rst) begin
                        re_prev = 1'b0;
                    end else begin
                        if (round_end) begin
                            chk("round_end_width", re_prev, 1'b0);
                            chk("busy_at_end", busy, 1'b0);
                            if (expq.size() == 0) begin
                                total++; bad++;
                                $display("FAIL unexpected_round_end: got pulse expected none");
                            end else begin
                                e = expq.pop_front();
                                chk("round_pass", round_pass, e[5]);
                                chk("hit_count_end", hit_count, e[4:0]);
                            end
                        end
                        re_prev = round_end;
                    end
                end
            end
        join_none

        repeat (3) @(negedge clk);
        chk("rst_led", led, 8'h00);
        chk("rst_busy", busy, 1'b0);
        chk("rst_hit", hit_count, 5'd0);
        chk("rst_end", round_end, 1'b0);
        chk("rst_pass", round_pass, 1'b0);
        rst = 1'b0;

        // Correct 4-step round: slots 3,0,7,2.
        pat = {36'h0, 3'd2, 3'd7, 3'd0, 3'd3};
        prs = '{8'h08, 8'h01, 8'h80, 8'h04};
        expq.push_back(model(4, pat, prs));
        do_start(3'b001, pat);
        chk("busy_after_start", busy, 1'b1);
        foreach (prs[i]) begin
            press(prs[i]);
            chk("hit_progress", hit_count, 5'(i + 1));
        end
        wait_idle();
        chk("pass_held", round_pass, 1'b1);

        // Wrong first press on an 8-step round: echo on led[4] for exactly 8 cycles.
        pat = {$urandom, $urandom} & ~48'h7 | 48'h5;
        expq.push_back({1'b0, 5'd0});
        do_start(3'b010, pat);
        chk("pass_cleared", round_pass, 1'b0);
        @(negedge clk);
        buttons = 8'h10;
        repeat (3) @(posedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("echo_lit", led, 8'h10);
        end
        @(negedge clk);
        chk("echo_off", led, 8'h00);
        buttons = 8'h00;
        wait_idle();

        // Two buttons in the same cycle count as a wrong press.
        expq.push_back({1'b0, 5'd0});
        do_start(3'b100, {$urandom, $urandom});
        press(8'h44);
        wait_idle();

        // Non-one-hot levels are ignored; presses in IDLE do nothing.
        do_start(3'b011, {$urandom, $urandom});
        repeat (3) @(negedge clk);
        chk("bad_level_busy", busy, 1'b0);
        do_start(3'b000, {$urandom, $urandom});
        repeat (3) @(negedge clk);
        chk("zero_level_busy", busy, 1'b0);
        press(8'h02);
        chk("idle_press_led", led, 8'h00);
        chk("idle_press_hit", hit_count, 5'd0);

        // Reset mid-round after two correct presses, then a fresh round.
        pat = {36'h0, 3'd4, 3'd3, 3'd2, 3'd1};
        do_start(3'b001, pat);
        press(8'h02);
        press(8'h04);
        chk("pre_reset_hit", hit_count, 5'd2);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("mid_rst_led", led, 8'h00);
        chk("mid_rst_busy", busy, 1'b0);
        chk("mid_rst_hit", hit_count, 5'd0);
        chk("mid_rst_end", round_end, 1'b0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        prs = '{8'h02, 8'h04, 8'h08, 8'h10};
        expq.push_back(model(4, pat, prs));
        do_start(3'b001, pat);
        foreach (prs[i]) press(prs[i]);
        wait_idle();

        // No press at all: timeout when enabled, otherwise wait forever.
        do_start(3'b001, {$urandom, $urandom});
`ifdef INPUT_TIMEOUT_EN
        expq.push_back({1'b0, 5'd0});
        cnt = 0;
        while (busy && cnt < 1100) begin
            cnt++;
            @(negedge clk);
        end
        chk("timeout_cycles", cnt, 1000);
        repeat (3) @(negedge clk);
`else
        repeat (1100) @(negedge clk);
        chk("no_timeout_busy", busy, 1'b1);
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(negedge clk);
        rst = 1'b0;
`endif

        // Randomized rounds with occasional wrong and multi-button presses.
        for (int r = 0; r < 20; r++) begin
            k = $urandom_range(0, 2);
            pat = {$urandom, $urandom};
            prs = {};
            res = 6'h3f;
            while (res == 6'h3f) begin
                int sel, a, b;
                int hits;
                hits = prs.size();
                sel = $urandom_range(0, 9);
                if (sel < 7) begin
                    prs.push_back(8'h01 << pat[3*hits +: 3]);
                end else if (sel == 7) begin
                    prs.push_back(8'h01 << $urandom_range(0, 7));
                end else begin
                    a = $urandom_range(0, 7);
                    b = (a + $urandom_range(1, 7)) % 8;
                    prs.push_back((8'h01 << a) | (8'h01 << b));
                end
                res = model(4 << k, pat, prs);
            end
            expq.push_back(res);
            do_start(3'b001 << k, pat);
            if ($urandom_range(0, 1) == 1) do_start(3'b001 << $urandom_range(0, 2), {$urandom, $urandom});
            foreach (prs[i]) press(prs[i]);
            wait_idle();
        end

        repeat (5) @(negedge clk);
        chk("queue_drained", expq.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/input_checker.md
INPUT_CHECKER -- requirements
Module: input_checker

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 1000, meaning the idle-input cycles allowed per press before the round fails (used only with INPUT_TIMEOUT_EN).
REQ-002 SHALL have parameter ECHO_CYCLES, default 8, meaning the number of cycles an echo LED stays lit after a press.
REQ-003 SHALL have port clk, input, 1 bit: the single system clock.
REQ-004 SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-005 SHALL have port start, input, 1 bit: pattern-ready pulse from the pattern generator (pattern_gen_end).
REQ-006 SHALL have port level, input, 3 bits: one-hot level (001 = 4 steps, 010 = 8 steps, 100 = 16 steps).
REQ-007 SHALL have port pattern_bus, input, 48 bits: pattern_1 at [2:0] through pattern_16 at [47:45]; each slot is a button index 0-7.
REQ-008 SHALL have port buttons, input, 8 bits: raw asynchronous buttons botton_1..botton_8 on bits [0]..[7].
REQ-009 SHALL have port led, output, 8 bits: press-echo LEDs with the same bit mapping as buttons.
REQ-010 SHALL have port busy, output, 1 bit: high while a round is collecting input.
REQ-011 SHALL have port hit_count, output, 5 bits: number of correct presses in the current round.
REQ-012 SHALL have port round_end, output, 1 bit: one-cycle pulse when the round finishes.
REQ-013 SHALL have port round_pass, output, 1 bit: result of the last round, valid from round_end and held until the next start.

Function
REQ-014 SHALL pass each button through two flip-flop synchronisers followed by rising-edge detection; a "press" is a cycle with exactly one rising edge.
REQ-015 SHALL treat two or more rising edges in the same cycle as one wrong press.
REQ-016 SHALL implement the states IDLE, COLLECT and DONE.
REQ-017 In IDLE, SHALL accept start only when level is exactly one-hot; it then latches pattern_bus and the step count (4, 8 or 16), clears hit_count, and enters COLLECT on the next cycle.
REQ-018 SHALL ignore start when level is 000 or not one-hot, and SHALL ignore start in COLLECT and DONE.
REQ-019 In COLLECT, SHALL compare a press against the latched slot hit_count; a match increments hit_count at the next clock edge.
REQ-020 SHALL fail the round on a mismatched press: round_pass=0 and a transition to DONE at the next edge, with hit_count unchanged.
REQ-021 SHALL pass the round when hit_count reaches the step count: round_pass=1 and a transition to DONE on the same edge that makes the final increment.
REQ-022 SHALL assert round_end for exactly the one cycle spent in DONE, then return to IDLE.
REQ-023 SHALL ignore presses in IDLE and DONE, with no counting and no echo.
REQ-024 SHALL light the echo LED for the pressed button for ECHO_CYCLES cycles on any COLLECT press, correct or wrong.
REQ-025 On a new press during an active echo, SHALL move the echo to the new LED and restart the echo counter.
REQ-026 SHALL set busy=1 exactly while in COLLECT.

Reset
REQ-027 SHALL, while rst is high, force the state to IDLE, led=0, busy=0, hit_count=0, round_end=0, round_pass=0, and clear the synchronisers and echo counter.
REQ-028 SHALL abandon a round in progress on reset mid-round without producing a round_end pulse.

Configuration
REQ-029 With INPUT_TIMEOUT_EN defined, SHALL count cycles in COLLECT since the last press (or since entry), and at TIMEOUT_CYCLES with no press SHALL fail the round (round_pass=0, then DONE).
REQ-030 SHALL reset the timeout counter on every COLLECT press.
REQ-031 Without INPUT_TIMEOUT_EN, SHALL contain no timeout counter; COLLECT then waits indefinitely.

Verification
REQ-032 SHALL pass this scenario: level=001, pattern slots 3,0,7,2, start, then press buttons[3],[0],[7],[2] -> hit_count goes 1,2,3,4; round_end pulses once; round_pass=1.
REQ-033 SHALL pass this scenario: level=010, slot 1=5, press buttons[4] first -> round_pass=0, hit_count=0, round_end pulses, led[4] lit for 8 cycles.
REQ-034 SHALL pass this scenario: level=100, press buttons[2] and buttons[6] in the same cycle -> counted as wrong, round_pass=0.
REQ-035 SHALL pass this scenario: level=011 with start -> state remains IDLE, busy=0, no round_end.
REQ-036 SHALL pass this scenario: rst asserted after 2 correct presses -> all outputs 0 immediately, no round_end; a new start then works normally.
REQ-037 SHALL pass this scenario, with INPUT_TIMEOUT_EN and TIMEOUT_CYCLES=1000: start and no press -> round_end after 1000 cycles in COLLECT with round_pass=0; without the macro, busy stays 1 indefinitely.
